// File: rtl/signed_sequential_divider_if.sv
// Handshake and result bundle shared by the signed sequential divider and its controller.
// The master drives start and the operands; the slave returns the result and status flags.
interface signed_sequential_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic             IsDone;
    logic             IsNeg;
    logic             DivZero;
    logic             Ovf;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, InA, InB,
        input  IsDone, IsNeg, DivZero, Ovf, quotient, remainder
    );

    modport slave (
        input  start, InA, InB,
        output IsDone, IsNeg, DivZero, Ovf, quotient, remainder
    );
endinterface

// File: rtl/signed_sequential_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// then a single fix-up cycle applies signs, truncating toward zero.
module signed_sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    signed_sequential_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        twos_neg = ~v + ONE_W;
    endfunction

    // The most-negative value maps onto its own bit pattern, read as unsigned 2^(W-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_val = twos_neg(v);
        end else begin
            abs_val = v;
        end
    endfunction

    state_t           state_r,    state_s;
    logic             sign_a_r,   sign_a_s;
    logic             sign_b_r,   sign_b_s;
    logic             ovf_pend_r, ovf_pend_s;
    logic [WIDTH-1:0] q_r,        q_s;
    logic [WIDTH-1:0] mag_b_r,    mag_b_s;
    logic [WIDTH:0]   rem_r,      rem_s;
    logic [CW-1:0]    cnt_r,      cnt_s;

    logic             done_r,     done_s;
    logic             neg_r,      neg_s;
    logic             dz_r,       dz_s;
    logic             ovf_r,      ovf_s;
    logic [WIDTH-1:0] quo_r,      quo_s;
    logic [WIDTH-1:0] rmd_r,      rmd_s;

    // One extra bit above the partial remainder so the trial subtraction's sign is its MSB.
    logic [WIDTH+1:0] shift_s;
    logic [WIDTH+1:0] diff_s;
    logic             neg_q_s;

    assign shift_s = {rem_r, q_r[WIDTH-1]};
    assign diff_s  = shift_s - {2'b00, mag_b_r};
    assign neg_q_s = sign_a_r ^ sign_b_r;

    // Next-state, datapath and result computation.
    always_comb begin
        state_s    = state_r;
        sign_a_s   = sign_a_r;
        sign_b_s   = sign_b_r;
        ovf_pend_s = ovf_pend_r;
        q_s        = q_r;
        mag_b_s    = mag_b_r;
        rem_s      = rem_r;
        cnt_s      = cnt_r;
        done_s     = done_r;
        neg_s      = neg_r;
        dz_s       = dz_r;
        ovf_s      = ovf_r;
        quo_s      = quo_r;
        rmd_s      = rmd_r;

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    sign_a_s   = bus.InA[WIDTH-1];
                    sign_b_s   = bus.InB[WIDTH-1];
                    q_s        = abs_val(bus.InA);
                    mag_b_s    = abs_val(bus.InB);
                    ovf_pend_s = (bus.InA == MIN_W) && (bus.InB == ONES_W);
                    rem_s      = {(WIDTH+1){1'b0}};
                    cnt_s      = {CW{1'b0}};
                    neg_s      = 1'b0;
                    ovf_s      = 1'b0;
                    quo_s      = ZERO_W;
                    if (bus.InB == ZERO_W) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        dz_s    = 1'b1;
                        rmd_s   = bus.InA;
                    end else begin
                        state_s = RUN;
                        done_s  = 1'b0;
                        dz_s    = 1'b0;
                        rmd_s   = ZERO_W;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            RUN: begin
                q_s   = {q_r[WIDTH-2:0], ~diff_s[WIDTH+1]};
                cnt_s = cnt_r + CNT_ONE;
                if (!diff_s[WIDTH+1]) begin
                    rem_s = diff_s[WIDTH:0];
                end else begin
                    rem_s = shift_s[WIDTH:0];
                end
                if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end

            FIX: begin
                state_s = DONE;
                done_s  = 1'b1;
                dz_s    = 1'b0;
                ovf_s   = ovf_pend_r;
                if (ovf_pend_r) begin
                    quo_s = MIN_W;
                    rmd_s = ZERO_W;
                    neg_s = 1'b0;
                end else begin
                    quo_s = neg_q_s ? twos_neg(q_r) : q_r;
                    rmd_s = sign_a_r ? twos_neg(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
                    neg_s = neg_q_s & (q_r != ZERO_W);
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            ovf_pend_r <= 1'b0;
            q_r        <= ZERO_W;
            mag_b_r    <= ZERO_W;
            rem_r      <= {(WIDTH+1){1'b0}};
            cnt_r      <= {CW{1'b0}};
            done_r     <= 1'b0;
            neg_r      <= 1'b0;
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
            quo_r      <= ZERO_W;
            rmd_r      <= ZERO_W;
        end else begin
            state_r    <= state_s;
            sign_a_r   <= sign_a_s;
            sign_b_r   <= sign_b_s;
            ovf_pend_r <= ovf_pend_s;
            q_r        <= q_s;
            mag_b_r    <= mag_b_s;
            rem_r      <= rem_s;
            cnt_r      <= cnt_s;
            done_r     <= done_s;
            neg_r      <= neg_s;
            dz_r       <= dz_s;
            ovf_r      <= ovf_s;
            quo_r      <= quo_s;
            rmd_r      <= rmd_s;
        end
    end

    assign bus.IsDone    = done_r;
    assign bus.IsNeg     = neg_r;
    assign bus.DivZero   = dz_r;
    assign bus.Ovf       = ovf_r;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rmd_r;
endmodule

// File: tb/tb_signed_sequential_divider.sv
// Directed and randomized self-checking bench for the signed sequential divider (WIDTH = 8).
module tb_signed_sequential_divider;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    signed_sequential_divider_if #(.WIDTH(WIDTH)) dut_bus ();

    signed_sequential_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one divide, then scrambles the operands and waits (bounded) for IsDone.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
        dut_bus.start = 1'b1;
        dut_bus.InA   = a;
        dut_bus.InB   = b;
        tick();
        dut_bus.start = 1'b0;
        dut_bus.InA   = 8'h5A;
        dut_bus.InB   = 8'hA5;
        lat = 0;
        while (!dut_bus.IsDone && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic neg, input logic dz, input logic ovf);
        check_value({tag, ".done"}, 32'(dut_bus.IsDone),    32'd1);
        check_value({tag, ".quo"},  32'(dut_bus.quotient),  32'(q));
        check_value({tag, ".rem"},  32'(dut_bus.remainder), 32'(r));
        check_value({tag, ".neg"},  32'(dut_bus.IsNeg),     32'(neg));
        check_value({tag, ".dz"},   32'(dut_bus.DivZero),   32'(dz));
        check_value({tag, ".ovf"},  32'(dut_bus.Ovf),       32'(ovf));
    endtask

    task automatic check_cleared(input string tag);
        check_value({tag, ".done"}, 32'(dut_bus.IsDone),    32'd0);
        check_value({tag, ".quo"},  32'(dut_bus.quotient),  32'd0);
        check_value({tag, ".rem"},  32'(dut_bus.remainder), 32'd0);
        check_value({tag, ".neg"},  32'(dut_bus.IsNeg),     32'd0);
        check_value({tag, ".dz"},   32'(dut_bus.DivZero),   32'd0);
        check_value({tag, ".ovf"},  32'(dut_bus.Ovf),       32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       neg;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         ai, bi, qi, ri;
        logic [7:0] a, b, eq, er, ident;
        logic       eneg, eovf, seen_done;

        vecs[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'd7,   8'hFE,  8'hFD, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{8'd3,   8'd7,   8'h00, 8'h03, 1'b0, 1'b0};
        vecs[7] = '{8'hFD,  8'd7,   8'h00, 8'hFD, 1'b0, 1'b0};
        vecs[8] = '{8'h80,  8'd2,   8'hC0, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'd127, 8'h80,  8'h00, 8'h7F, 1'b0, 1'b0};

        // Reset held with start high: reset must win.
        rst_n         = 1'b0;
        dut_bus.start = 1'b1;
        dut_bus.InA   = 8'd100;
        dut_bus.InB   = 8'd7;
        tick();
        tick();
        check_cleared("reset");
        rst_n         = 1'b1;
        dut_bus.start = 1'b0;
        tick();
        tick();
        check_value("idle.done", 32'(dut_bus.IsDone), 32'd0);

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, lat);
            check_value($sformatf("dir%0d.lat", i), 32'(lat), 32'd9);
            check_result($sformatf("dir%0d", i), vecs[i].q, vecs[i].r, vecs[i].neg, 1'b0, vecs[i].ovf);
        end

        // Divide by zero finishes on the accept edge.
        run_div(8'd5, 8'd0, lat);
        check_value("dz5.lat", 32'(lat), 32'd0);
        check_result("dz5", 8'h00, 8'h05, 1'b0, 1'b1, 1'b0);
        run_div(8'hF9, 8'd0, lat);
        check_value("dzm7.lat", 32'(lat), 32'd0);
        check_result("dzm7", 8'h00, 8'hF9, 1'b0, 1'b1, 1'b0);

        // start pulsed mid-RUN is ignored; flags cleared on accept.
        dut_bus.start = 1'b1;
        dut_bus.InA   = 8'd100;
        dut_bus.InB   = 8'd7;
        tick();
        dut_bus.start = 1'b0;
        check_value("acc.done_clr", 32'(dut_bus.IsDone),  32'd0);
        check_value("acc.dz_clr",   32'(dut_bus.DivZero), 32'd0);
        tick();
        tick();
        tick();
        dut_bus.start = 1'b1;
        dut_bus.InA   = 8'd9;
        dut_bus.InB   = 8'd3;
        tick();
        dut_bus.start = 1'b0;
        lat = 4;
        while (!dut_bus.IsDone && lat < 20) begin
            tick();
            lat++;
        end
        check_value("ign.lat", 32'(lat), 32'd9);
        check_result("ign", 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);

        // Reset mid-RUN aborts; no partial result and no later IsDone.
        run_div(8'd100, 8'd7, lat);
        dut_bus.start = 1'b1;
        dut_bus.InA   = 8'd100;
        dut_bus.InB   = 8'd7;
        tick();
        dut_bus.start = 1'b0;
        tick();
        tick();
        tick();
        check_value("midrun.quo", 32'(dut_bus.quotient), 32'd0);
        check_value("midrun.done", 32'(dut_bus.IsDone), 32'd0);
        rst_n = 1'b0;
        tick();
        check_cleared("abort");
        rst_n     = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen_done = seen_done | dut_bus.IsDone;
        end
        check_value("abort.no_done", 32'(seen_done), 32'd0);

        // start held high: DONE restarts immediately, back-to-back.
        dut_bus.start = 1'b1;
        dut_bus.InA   = 8'd100;
        dut_bus.InB   = 8'd7;
        tick();
        lat = 0;
        while (!dut_bus.IsDone && lat < 20) begin
            tick();
            lat++;
        end
        check_value("b2b1.lat", 32'(lat), 32'd9);
        check_result("b2b1", 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);
        dut_bus.InA = 8'h9C;
        tick();
        check_value("b2b.restart", 32'(dut_bus.IsDone), 32'd0);
        dut_bus.start = 1'b0;
        lat = 0;
        while (!dut_bus.IsDone && lat < 20) begin
            tick();
            lat++;
        end
        check_value("b2b2.lat", 32'(lat), 32'd9);
        check_result("b2b2", 8'hF2, 8'hFE, 1'b1, 1'b0, 1'b0);

        // Random sweep against native integer division.
        for (int n = 0; n < 80; n++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 1));
            if (n == 0) begin
                a = 8'h80;
                b = 8'h80;
            end
            ai   = $signed(a);
            bi   = $signed(b);
            qi   = ai / bi;
            ri   = ai % bi;
            eq   = qi[7:0];
            er   = ri[7:0];
            eovf = (a == 8'h80) && (b == 8'hFF);
            eneg = (qi != 0) && ((ai < 0) != (bi < 0));
            run_div(a, b, lat);
            check_value($sformatf("rnd%0d.lat", n), 32'(lat), 32'd9);
            check_result($sformatf("rnd%0d(%0d/%0d)", n, ai, bi), eq, er, eneg, 1'b0, eovf);
            ident = 8'(dut_bus.quotient * b + dut_bus.remainder);
            check_value($sformatf("rnd%0d.ident", n), 32'(ident), 32'(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
